// File: rtl/axi_enhanced_pcie_rx_pkg.sv
// -----------------------------------------------------------------------------
// axi_enhanced_pcie_rx_pkg
// Shared constants and types for the AXI-enhanced PCIe RX path.
//   - Supported RX datapath widths and a helper that validates a width.
//   - Discontinue-control FSM state encoding.
//   - Width, type and saturation value of the discontinue counter.
// -----------------------------------------------------------------------------
package axi_enhanced_pcie_rx_pkg;

  // Supported RX datapath widths.
  localparam int RX_DW_128 = 128;
  localparam int RX_DW_64  = 64;
  localparam int RX_DW_32  = 32;

  // Discontinue counter.
  localparam int DSC_CNT_W = 16;
  typedef logic [DSC_CNT_W-1:0] dsc_cnt_t;
  localparam dsc_cnt_t DSC_CNT_MAX = {DSC_CNT_W{1'b1}};

  // Discontinue-control states.
  //   PASS      : source data flows to the user untouched
  //   NULL_FILL : null generator closes the user's open packet while the
  //               source is drained
  //   DRAIN     : source is drained until its end-of-frame, nothing is shown
  typedef enum logic [1:0] {
    RX_DSC_PASS      = 2'd0,
    RX_DSC_NULL_FILL = 2'd1,
    RX_DSC_DRAIN     = 2'd2
  } rx_dsc_state_e;

  function automatic bit rx_width_ok(input int width);
    return (width == RX_DW_128) || (width == RX_DW_64) || (width == RX_DW_32);
  endfunction

endpackage

// File: rtl/axi_enhanced_rx_dsc_ctl.sv
// -----------------------------------------------------------------------------
// axi_enhanced_rx_dsc_ctl
// Handles a TRN discontinue (trn_rsrc_dsc) on the RX path. If the user is in
// the middle of a packet, the null generator is muxed onto AXI RX to close it
// cleanly while the source frame is drained; otherwise the source frame is
// simply drained. Every discontinue accepted in PASS is counted.
//
// Ports
//   com_iclk          : clock, rising edge
//   com_sysrst        : synchronous active-high reset
//   trn_rsrc_rdy      : TRN source beat valid
//   trn_reof          : TRN end-of-frame
//   trn_rsrc_dsc      : TRN discontinue
//   m_axis_rx_tvalid  : AXI RX valid   (observed)
//   m_axis_rx_tready  : AXI RX ready   (observed)
//   m_axis_rx_tlast   : AXI RX last    (observed)
//   null_rx_tlast     : null generator last-beat flag
//   null_mux_sel      : 1 = null source drives AXI RX
//   trn_rdst_rdy_ovr  : force trn_rdst_rdy high to drain the source
//   dsc_event         : one-cycle pulse per accepted discontinue
//   dsc_count         : saturating count of accepted discontinues
//
// All outputs are decoded from registers only.
// -----------------------------------------------------------------------------
module axi_enhanced_rx_dsc_ctl
  import axi_enhanced_pcie_rx_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128,
  parameter int TCQ          = 1
) (
  input  logic                 com_iclk,
  input  logic                 com_sysrst,
  input  logic                 trn_rsrc_rdy,
  input  logic                 trn_reof,
  input  logic                 trn_rsrc_dsc,
  input  logic                 m_axis_rx_tvalid,
  input  logic                 m_axis_rx_tready,
  input  logic                 m_axis_rx_tlast,
  input  logic                 null_rx_tlast,
  output logic                 null_mux_sel,
  output logic                 trn_rdst_rdy_ovr,
  output logic                 dsc_event,
  output logic [DSC_CNT_W-1:0] dsc_count
);

  // Elaboration-time parameter sanity. Neither parameter shapes the logic:
  // the controller only watches 1-bit handshake flags, and registers carry
  // no modelled clock-to-Q delay.
  if (!rx_width_ok(C_DATA_WIDTH)) begin : g_unsupported_width
  end
  if (TCQ < 0) begin : g_negative_tcq
  end

  rx_dsc_state_e state_reg, state_next;
  logic          user_in_pkt_reg, user_in_pkt_next;
  logic          src_eof_seen_reg, src_eof_seen_next;
  logic          dsc_event_reg, dsc_accept;
  dsc_cnt_t      dsc_count_reg;

  logic user_accept, user_tlast_accept, src_eof, null_done;

  assign user_accept       = m_axis_rx_tvalid & m_axis_rx_tready;
  assign user_tlast_accept = user_accept & m_axis_rx_tlast;
  assign src_eof           = trn_rsrc_rdy & trn_reof;
  assign null_done         = m_axis_rx_tready & null_rx_tlast;

  always_comb begin
    state_next        = state_reg;
    src_eof_seen_next = src_eof_seen_reg;
    user_in_pkt_next  = user_in_pkt_reg;
    dsc_accept        = 1'b0;

    if (user_accept) begin
      user_in_pkt_next = ~m_axis_rx_tlast;
    end

    unique case (state_reg)
      RX_DSC_PASS: begin
        if (trn_rsrc_dsc) begin
          dsc_accept = 1'b1;
          if (user_in_pkt_reg && !user_tlast_accept) begin
            state_next = RX_DSC_NULL_FILL;
          end else if (!src_eof) begin
            // Frame already ending this cycle: nothing left to drain.
            state_next = RX_DSC_DRAIN;
          end
        end
      end
      RX_DSC_NULL_FILL: begin
        if (null_done) begin
          // Source frame may still be open once the null packet closes.
          state_next        = (src_eof_seen_reg || src_eof) ? RX_DSC_PASS
                                                            : RX_DSC_DRAIN;
          src_eof_seen_next = 1'b0;
        end else if (src_eof) begin
          src_eof_seen_next = 1'b1;
        end
      end
      RX_DSC_DRAIN: begin
        if (src_eof) begin
          state_next = RX_DSC_PASS;
        end
      end
      default: begin
        state_next = RX_DSC_PASS;
      end
    endcase
  end

  always_ff @(posedge com_iclk) begin
    if (com_sysrst) begin
      state_reg        <= RX_DSC_PASS;
      user_in_pkt_reg  <= 1'b0;
      src_eof_seen_reg <= 1'b0;
      dsc_event_reg    <= 1'b0;
      dsc_count_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      user_in_pkt_reg  <= user_in_pkt_next;
      src_eof_seen_reg <= src_eof_seen_next;
      dsc_event_reg    <= dsc_accept;
      if (dsc_accept && (dsc_count_reg != DSC_CNT_MAX)) begin
        dsc_count_reg <= dsc_count_reg + 1'b1;
      end
    end
  end

  assign null_mux_sel     = (state_reg == RX_DSC_NULL_FILL);
  assign trn_rdst_rdy_ovr = (state_reg != RX_DSC_PASS);
  assign dsc_event        = dsc_event_reg;
  assign dsc_count        = dsc_count_reg;

endmodule

// File: tb/tb_axi_enhanced_rx_dsc_ctl.sv
// -----------------------------------------------------------------------------
// tb_axi_enhanced_rx_dsc_ctl
// Directed scenarios plus a randomized run against a behavioural model of the
// discontinue controller.
// -----------------------------------------------------------------------------
module tb_axi_enhanced_rx_dsc_ctl;

  logic        com_iclk = 1'b0;
  logic        com_sysrst;
  logic        trn_rsrc_rdy, trn_reof, trn_rsrc_dsc;
  logic        m_axis_rx_tvalid, m_axis_rx_tready, m_axis_rx_tlast;
  logic        null_rx_tlast;
  logic        null_mux_sel, trn_rdst_rdy_ovr, dsc_event;
  logic [15:0] dsc_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: "closing the user's packet" and "draining the source"
  // as two booleans; neither means normal passthrough.
  bit          m_closing, m_draining, m_user_open, m_eof_noted, m_evt;
  int unsigned m_cnt;

  always #5 com_iclk = ~com_iclk;

  axi_enhanced_rx_dsc_ctl #(.C_DATA_WIDTH(128), .TCQ(1)) dut (
    .com_iclk         (com_iclk),
    .com_sysrst       (com_sysrst),
    .trn_rsrc_rdy     (trn_rsrc_rdy),
    .trn_reof         (trn_reof),
    .trn_rsrc_dsc     (trn_rsrc_dsc),
    .m_axis_rx_tvalid (m_axis_rx_tvalid),
    .m_axis_rx_tready (m_axis_rx_tready),
    .m_axis_rx_tlast  (m_axis_rx_tlast),
    .null_rx_tlast    (null_rx_tlast),
    .null_mux_sel     (null_mux_sel),
    .trn_rdst_rdy_ovr (trn_rdst_rdy_ovr),
    .dsc_event        (dsc_event),
    .dsc_count        (dsc_count)
  );

  task automatic idle_inputs();
    com_sysrst = 1'b0; trn_rsrc_rdy = 1'b0; trn_reof = 1'b0; trn_rsrc_dsc = 1'b0;
    m_axis_rx_tvalid = 1'b0; m_axis_rx_tready = 1'b0; m_axis_rx_tlast = 1'b0;
    null_rx_tlast = 1'b0;
  endtask

  // Advance one clock; outputs are then stable for sampling.
  task automatic tick();
    @(posedge com_iclk);
    #1;
  endtask

  // Predict the effect of the inputs currently driven at the next edge.
  task automatic model_update();
    bit accepted, last_accepted, frame_end, closing_n, draining_n;
    accepted      = m_axis_rx_tvalid && m_axis_rx_tready;
    last_accepted = accepted && m_axis_rx_tlast;
    frame_end     = trn_rsrc_rdy && trn_reof;
    closing_n     = m_closing;
    draining_n    = m_draining;
    m_evt         = 1'b0;
    if (com_sysrst) begin
      m_closing = 0; m_draining = 0; m_user_open = 0; m_eof_noted = 0; m_cnt = 0;
      return;
    end
    if (!m_closing && !m_draining) begin
      if (trn_rsrc_dsc) begin
        m_evt = 1'b1;
        if (m_cnt < 65535) m_cnt++;
        if (m_user_open && !last_accepted) closing_n = 1;
        else if (!frame_end)                draining_n = 1;
      end
    end else if (m_closing) begin
      if (m_axis_rx_tready && null_rx_tlast) begin
        closing_n     = 0;
        draining_n    = !(m_eof_noted || frame_end);
        m_eof_noted   = 0;
      end else if (frame_end) begin
        m_eof_noted = 1;
      end
    end else if (frame_end) begin
      draining_n = 0;
    end
    if (accepted) m_user_open = !m_axis_rx_tlast;
    m_closing  = closing_n;
    m_draining = draining_n;
  endtask

  task automatic test_reset();
    idle_inputs();
    com_sysrst = 1'b1;
    tick(); tick();
    n_tests++;
    if ({null_mux_sel, trn_rdst_rdy_ovr, dsc_event} !== 3'b000 || dsc_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: sel/ovr/evt=%b%b%b cnt=%0d, required 000 cnt=0",
               null_mux_sel, trn_rdst_rdy_ovr, dsc_event, dsc_count);
    end
    com_sysrst = 1'b0;
    tick();
    $display("[TB] reset: sel=%b ovr=%b evt=%b cnt=%0d", null_mux_sel, trn_rdst_rdy_ovr, dsc_event, dsc_count);
  endtask

  // 4-beat packet, dsc on beat 2, eof during fill, null tlast 2 cycles later.
  task automatic test_null_fill();
    idle_inputs();
    m_axis_rx_tvalid = 1; m_axis_rx_tready = 1;            // beat 1
    tick();
    trn_rsrc_dsc = 1;                                       // beat 2 + dsc
    tick();
    n_tests++;
    if ({null_mux_sel, trn_rdst_rdy_ovr, dsc_event} !== 3'b111 || dsc_count !== 16'd1) begin
      n_fail++;
      $display("FAIL null_fill_entry: sel/ovr/evt=%b%b%b cnt=%0d, required 111 cnt=1",
               null_mux_sel, trn_rdst_rdy_ovr, dsc_event, dsc_count);
    end
    trn_rsrc_dsc = 0; m_axis_rx_tready = 0;
    trn_rsrc_rdy = 1; trn_reof = 1;                         // source eof seen
    tick();
    n_tests++;
    if ({null_mux_sel, trn_rdst_rdy_ovr, dsc_event} !== 3'b110) begin
      n_fail++;
      $display("FAIL null_fill_hold: sel/ovr/evt=%b%b%b, required 110",
               null_mux_sel, trn_rdst_rdy_ovr, dsc_event);
    end
    trn_rsrc_rdy = 0; trn_reof = 0;
    m_axis_rx_tready = 1; m_axis_rx_tlast = 1; null_rx_tlast = 1;  // null tlast
    tick();
    n_tests++;
    if ({null_mux_sel, trn_rdst_rdy_ovr} !== 2'b00 || dsc_count !== 16'd1) begin
      n_fail++;
      $display("FAIL null_fill_exit: sel/ovr=%b%b cnt=%0d, required 00 cnt=1",
               null_mux_sel, trn_rdst_rdy_ovr, dsc_count);
    end
    idle_inputs();
    tick();
    $display("[TB] null_fill: exit sel=%b ovr=%b cnt=%0d", null_mux_sel, trn_rdst_rdy_ovr, dsc_count);
  endtask

  // dsc with no open packet, eof 3 cycles later.
  task automatic test_drain();
    bit seen_sel = 0;
    idle_inputs();
    trn_rsrc_dsc = 1;
    tick();
    trn_rsrc_dsc = 0;
    for (int i = 0; i < 3; i++) begin
      seen_sel |= null_mux_sel;
      n_tests++;
      if (trn_rdst_rdy_ovr !== 1'b1 || dsc_event !== (i == 0)) begin
        n_fail++;
        $display("FAIL drain_cycle%0d: ovr=%b evt=%b, required ovr=1 evt=%b",
                 i, trn_rdst_rdy_ovr, dsc_event, i == 0);
      end
      if (i == 2) begin trn_rsrc_rdy = 1; trn_reof = 1; end
      tick();
    end
    seen_sel |= null_mux_sel;
    n_tests++;
    if (trn_rdst_rdy_ovr !== 1'b0 || seen_sel !== 1'b0 || dsc_count !== 16'd2) begin
      n_fail++;
      $display("FAIL drain_exit: ovr=%b sel_seen=%b cnt=%0d, required 0 0 cnt=2",
               trn_rdst_rdy_ovr, seen_sel, dsc_count);
    end
    idle_inputs();
    tick();
    $display("[TB] drain: exit ovr=%b cnt=%0d", trn_rdst_rdy_ovr, dsc_count);
  endtask

  // dsc while filling with tready low for 5 cycles: ignored, state held.
  task automatic test_null_hold();
    idle_inputs();
    m_axis_rx_tvalid = 1; m_axis_rx_tready = 1;
    tick();
    trn_rsrc_dsc = 1;
    tick();                                    // now filling, count 3
    m_axis_rx_tready = 0; null_rx_tlast = 1;   // dsc still asserted
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (null_mux_sel !== 1'b1 || dsc_count !== 16'd3 || dsc_event !== 1'b0) begin
        n_fail++;
        $display("FAIL null_hold%0d: sel=%b cnt=%0d evt=%b, required sel=1 cnt=3 evt=0",
                 i, null_mux_sel, dsc_count, dsc_event);
      end
    end
    trn_rsrc_dsc = 0; m_axis_rx_tready = 1; m_axis_rx_tlast = 1;  // close, no eof
    tick();
    n_tests++;
    if ({null_mux_sel, trn_rdst_rdy_ovr} !== 2'b01) begin
      n_fail++;
      $display("FAIL null_to_drain: sel/ovr=%b%b, required 01", null_mux_sel, trn_rdst_rdy_ovr);
    end
    idle_inputs();
    trn_rsrc_rdy = 1; trn_reof = 1;
    tick();
    idle_inputs();
    $display("[TB] null_hold: after eof ovr=%b cnt=%0d", trn_rdst_rdy_ovr, dsc_count);
  endtask

  // dsc coincident with tlast accept and eof: stays in passthrough.
  task automatic test_coincident();
    idle_inputs();
    m_axis_rx_tvalid = 1; m_axis_rx_tready = 1;
    tick();
    m_axis_rx_tlast = 1; trn_rsrc_dsc = 1; trn_rsrc_rdy = 1; trn_reof = 1;
    tick();
    n_tests++;
    if ({null_mux_sel, trn_rdst_rdy_ovr, dsc_event} !== 3'b001 || dsc_count !== 16'd4) begin
      n_fail++;
      $display("FAIL coincident: sel/ovr/evt=%b%b%b cnt=%0d, required 001 cnt=4",
               null_mux_sel, trn_rdst_rdy_ovr, dsc_event, dsc_count);
    end
    idle_inputs();
    tick();
    n_tests++;
    if (dsc_event !== 1'b0 || trn_rdst_rdy_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL coincident_pulse: evt=%b ovr=%b, required 0 0", dsc_event, trn_rdst_rdy_ovr);
    end
    $display("[TB] coincident: cnt=%0d", dsc_count);
  endtask

  task automatic test_reset_in_drain();
    idle_inputs();
    trn_rsrc_dsc = 1;
    tick();                                     // draining
    com_sysrst = 1;
    tick();
    n_tests++;
    if ({null_mux_sel, trn_rdst_rdy_ovr, dsc_event} !== 3'b000 || dsc_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_in_drain: sel/ovr/evt=%b%b%b cnt=%0d, required 000 cnt=0",
               null_mux_sel, trn_rdst_rdy_ovr, dsc_event, dsc_count);
    end
    idle_inputs();
    tick();
    n_tests++;
    if ({null_mux_sel, trn_rdst_rdy_ovr} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_residual: sel/ovr=%b%b, required 00", null_mux_sel, trn_rdst_rdy_ovr);
    end
    $display("[TB] reset_in_drain: sel=%b ovr=%b", null_mux_sel, trn_rdst_rdy_ovr);
  endtask

  task automatic test_random();
    int errs = 0;
    idle_inputs();
    com_sysrst = 1;
    model_update();
    tick();
    for (int i = 0; i < 3000; i++) begin
      com_sysrst       = ($urandom_range(0, 299) == 0);
      trn_rsrc_rdy     = $urandom_range(0, 1);
      trn_reof         = ($urandom_range(0, 3) == 0);
      trn_rsrc_dsc     = ($urandom_range(0, 5) == 0);
      m_axis_rx_tvalid = $urandom_range(0, 1);
      m_axis_rx_tready = ($urandom_range(0, 3) != 0);
      m_axis_rx_tlast  = ($urandom_range(0, 3) == 0);
      null_rx_tlast    = ($urandom_range(0, 2) == 0);
      model_update();
      tick();
      n_tests++;
      if (null_mux_sel !== m_closing || trn_rdst_rdy_ovr !== (m_closing || m_draining) ||
          dsc_event !== m_evt || dsc_count !== m_cnt[15:0]) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL random_cyc%0d: sel=%b ovr=%b evt=%b cnt=%0d, required sel=%b ovr=%b evt=%b cnt=%0d",
                   i, null_mux_sel, trn_rdst_rdy_ovr, dsc_event, dsc_count,
                   m_closing, m_closing || m_draining, m_evt, m_cnt);
      end
    end
    idle_inputs();
    $display("[TB] random: 3000 cycles, final cnt=%0d model=%0d", dsc_count, m_cnt);
  endtask

  task automatic test_saturate();
    idle_inputs();
    com_sysrst = 1;
    tick();
    com_sysrst = 0;
    trn_rsrc_dsc = 1; trn_rsrc_rdy = 1; trn_reof = 1;  // isolated: stays in passthrough
    for (int i = 1; i <= 65540; i++) begin
      tick();
      if (i == 65534) begin
        n_tests++;
        if (dsc_count !== 16'hFFFE) begin
          n_fail++;
          $display("FAIL sat_before: cnt=%h, required fffe", dsc_count);
        end
      end
    end
    n_tests++;
    if (dsc_count !== 16'hFFFF || trn_rdst_rdy_ovr !== 1'b0 || dsc_event !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: cnt=%h ovr=%b evt=%b, required ffff 0 1",
               dsc_count, trn_rdst_rdy_ovr, dsc_event);
    end
    idle_inputs();
    tick();
    $display("[TB] saturate: 65540 discontinues, cnt=%h", dsc_count);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_null_fill();
    test_drain();
    test_null_hold();
    test_coincident();
    test_reset_in_drain();
    test_random();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
